// File: rtl/issue_select.sv
// issue_select: picks one ready reservation-station entry per cycle and
// parks it in a single-entry output register feeding the execute unit.
//
// Ports
//   clk, rst_n       clock, async active-low reset
//   flush            discard the held op; suppresses this cycle's grant
//   entry_ready_in   per-entry occupied-and-ready flags
//   entries_in       per-entry contents (res_st_cell_t)
//   issue_grant_out  one-hot (or zero) grant; RS frees that entry next edge
//   op_out           registered op for execute
//   op_valid_out     op_out is valid
//   op_ready_in      execute accepts op_out this cycle
//   issue_count_out  saturating count of accepted ops
//
// Config macro: QU_ISSUE_ROUND_ROBIN_EN
//   defined   -> round-robin scan starting at rr_ptr
//   undefined -> fixed priority, lowest index wins (no rr_ptr state)

package issue_select_pkg;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [5:0]  dst_tag;
    logic [31:0] imm;
  } res_st_cell_t;
endpackage

module issue_select
  import issue_select_pkg::*;
#(
  parameter int NUM_ENTRIES = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic         [NUM_ENTRIES-1:0]    entry_ready_in,
  input  res_st_cell_t [NUM_ENTRIES-1:0]    entries_in,
  output logic         [NUM_ENTRIES-1:0]    issue_grant_out,
  output res_st_cell_t                      op_out,
  output logic                              op_valid_out,
  input  logic                              op_ready_in,
  output logic         [15:0]               issue_count_out
);
  localparam int PW = $clog2(NUM_ENTRIES);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]    state_q, state_d;
  res_st_cell_t  op_q, op_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          slot_free, handshake, found, grant_ok;
  logic [PW-1:0] gidx, cand;
  int            scan_idx;
`ifdef QU_ISSUE_ROUND_ROBIN_EN
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // Slot can take a new op if empty or if its current op leaves this cycle.
  assign slot_free = (state_q == ST_EMPTY) || op_ready_in;
  assign handshake = (state_q == ST_FULL) && op_ready_in;

  // First ready entry in scan order; scan starts at rr_ptr when RR is enabled.
  always_comb begin
    found    = 1'b0;
    gidx     = '0;
    cand     = '0;
    scan_idx = 0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
`ifdef QU_ISSUE_ROUND_ROBIN_EN
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NUM_ENTRIES) scan_idx = scan_idx - NUM_ENTRIES;
`else
      scan_idx = k;
`endif
      cand = PW'(scan_idx);
      if (!found && entry_ready_in[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
  end

  // rst_n gates the grant so the RS never frees an entry while we are in reset.
  assign grant_ok = rst_n && slot_free && !flush && found;

  always_comb begin
    issue_grant_out = '0;
    if (grant_ok) issue_grant_out[gidx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    // A handshake counts even when flush discards the slot the same cycle.
    if (handshake && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (grant_ok) begin
      state_d = ST_FULL;
      op_d    = entries_in[gidx];
    end else if (slot_free) begin
      state_d = ST_EMPTY;
    end
  end

`ifdef QU_ISSUE_ROUND_ROBIN_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_ok) begin
      if (gidx == PW'(NUM_ENTRIES - 1)) rr_ptr_d = '0;
      else                              rr_ptr_d = gidx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign op_out          = op_q;
  assign op_valid_out    = (state_q == ST_FULL);
  assign issue_count_out = cnt_q;

endmodule
